ysyx_22041211_mem_responder: RTL and testbench
==============================================

// Module: ysyx_22041211_mem_responder
// PURPOSE
//  Memory-side responder for the core's load/store data port. It accepts one
//  request at a time over a valid/ready handshake and models access latency.
//  It owns the byte-lane decode and a synthesizable word-organised RAM, and
//  returns right-aligned read data; sign extension stays in the core.
//  Sits behind the core's data-memory port and replaces the pmem_* DPI calls
//  for synthesizable builds.
// PARAMETERS
//  DATA_LEN    32            data width (fixed 32; other values unsupported)
//  ADDR_LEN    32            request address width
//  DEPTH_LOG2  10            log2 of RAM words (default 1024 words = 4 KiB)
//  BASE_ADDR   32'h80000000  byte address of RAM word 0
//  LATENCY     2             wait cycles between accept and response, 0..15
// PORTS
//  clk        input   1         clock, rising edge
//  rst        input   1         asynchronous active-low reset
//  req_valid  input   1         request present
//  req_ready  output  1         responder can accept a request
//  req_wen    input   1         1 = store, 0 = load
//  req_size   input   2         0 = byte, 1 = half, 2 = word, 3 = reserved
//  req_addr   input   ADDR_LEN  byte address
//  req_wdata  input   DATA_LEN  store data, right-aligned (bits [7:0] = byte 0)
//  rsp_valid  output  1         response present
//  rsp_ready  input   1         requester accepts response
//  rsp_rdata  output  DATA_LEN  load data, right-aligned, upper bits zero
//  rsp_err    output  1         access fault (range, misalign, reserved size)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, counter=0. RAM contents are not cleared.
//  FSM states: IDLE, BUSY, RESP.
//   IDLE: req_ready=1. On req_valid&req_ready, capture wen/size/addr/wdata.
//         Go to BUSY with cnt=LATENCY-1 if LATENCY>0, else go to RESP.
//   BUSY: req_ready=0. Decrement cnt each cycle. At cnt==0, do the access and
//         go to RESP on the next edge.
//   RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until
//         rsp_valid&rsp_ready, then go to IDLE. No combinational ready path.
//  Latency: accept edge to rsp_valid high is LATENCY+1 cycles. Back-to-back
//   minimum issue interval is LATENCY+2 cycles.
//  Decode:
//   off = addr - BASE_ADDR (modulo 2^ADDR_LEN); idx = off[DEPTH_LOG2+1:2].
//   Range fault: off >= 4<<DEPTH_LOG2.
//   Misalign fault: size=1 with addr[0]=1, or size=2 with addr[1:0]!=0.
//   size=3 is a fault.
//  Lane mask: byte=4'b0001<<addr[1:0]; half=4'b0011<<addr[1:0]; word=4'b1111.
//  Store: for each lane i set in the mask, RAM[idx] byte i is written with the
//   data byte shifted up by 8*addr[1:0]. Unmasked bytes are preserved.
//   rsp_rdata=0.
//  Load: rsp_rdata=(RAM[idx]>>(8*addr[1:0])) masked to size; upper bits zero.
//  On any fault: no RAM write, rsp_rdata=0, rsp_err=1. A response is still
//   produced.
//  Access takes effect exactly once per accepted request, at the BUSY->RESP
//   edge (or the accept edge when LATENCY=0). Stalling in RESP never repeats it.
//  req_* changes while not in IDLE are ignored (captured copy is used).
//  Reset mid-BUSY or mid-RESP: request is dropped, no write occurs (if not yet
//   committed), FSM returns to IDLE, and no response is issued.
// TESTING
//  1 Word store 0xDEADBEEF @0x80000010, then word load same address ->
//    rdata=0xDEADBEEF, err=0, rsp_valid exactly LATENCY+1 cycles after accept.
//  2 Byte store 0xA5 @0x80000012 over the test 1 word, then word load @0x80000010
//    -> 0xDEA5BEEF. Byte load @0x80000012 -> 0x000000A5.
//  3 Half load @0x80000012 -> 0x0000DEA5. Half load @0x80000011 -> err=1,
//    rdata=0, RAM unchanged.
//  4 Word store @0x7FFFFFFC and @(BASE+4096) -> err=1 both, and a subsequent
//    load at BASE+0 shows no corruption.
//  5 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata/err stable,
//    req_ready=0. Store not repeated (check with a read-back).
//  6 Assert rst low during BUSY of a store -> rsp_valid=0, req_ready=1
//    immediately, and a read-back of the target word shows the old value.
//    Repeat with LATENCY=0 for a 1-cycle response.

Source files
------------

// File: rtl/ysyx_22041211_mem_responder.sv
// Memory-side responder for the core's load/store data port: valid/ready request,
// fixed access latency, byte-lane decode over a word-organised RAM, right-aligned read data.
module ysyx_22041211_mem_responder #(
  parameter int                  DATA_LEN   = 32,
  parameter int                  ADDR_LEN   = 32,
  parameter int                  DEPTH_LOG2 = 10,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                  LATENCY    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [1:0]          req_size,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_rdata,
  output logic                rsp_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [ADDR_LEN-1:0] RAM_BYTES = ADDR_LEN'(4) << DEPTH_LOG2;
  localparam logic [3:0]          CNT_INIT  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wen_q, wen_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_LEN-1:0]   addr_q, addr_d;
  logic [DATA_LEN-1:0]   wdata_q, wdata_d;
  logic [DATA_LEN-1:0]   rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_LEN-1:0]   mem [DEPTH];

  logic                  fire, acc_en, we, fault;
  logic                  acc_wen;
  logic [1:0]            acc_size, bsel;
  logic [ADDR_LEN-1:0]   acc_addr, off;
  logic [DATA_LEN-1:0]   acc_wdata, wdata_sh, rd_word, rd_sh, size_mask;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]            lane_mask;

  assign fire      = req_valid & req_ready;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With zero latency the access happens on the accept edge, so the live request is used.
  assign acc_en = (LATENCY == 0) ? (state_q == IDLE && fire) : (state_q == BUSY && cnt_q == 4'd0);
  assign we     = acc_en & acc_wen & ~fault & rst;

  always_comb begin
    acc_wen   = (state_q == IDLE) ? req_wen   : wen_q;
    acc_size  = (state_q == IDLE) ? req_size  : size_q;
    acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    off       = acc_addr - BASE_ADDR;
    idx       = off[DEPTH_LOG2+1:2];
    bsel      = acc_addr[1:0];
    fault     = (off >= RAM_BYTES) || (acc_size == 2'd3) ||
                (acc_size == 2'd1 && bsel[0]) || (acc_size == 2'd2 && bsel != 2'd0);
    lane_mask = 4'b0000;
    size_mask = '0;
    case (acc_size)
      2'd0: begin lane_mask = 4'b0001 << bsel; size_mask = DATA_LEN'(32'h0000_00FF); end
      2'd1: begin lane_mask = 4'b0011 << bsel; size_mask = DATA_LEN'(32'h0000_FFFF); end
      2'd2: begin lane_mask = 4'b1111;         size_mask = '1; end
      default: ;
    endcase
    wdata_sh = acc_wdata << {bsel, 3'b000};
    rd_word  = mem[idx];
    rd_sh    = (rd_word >> {bsel, 3'b000}) & size_mask;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (fire) begin
        wen_d   = req_wen;
        size_d  = req_size;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        cnt_d   = CNT_INIT;
        state_d = (LATENCY > 0) ? BUSY : RESP;
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (acc_en) begin
      rdata_d = (fault || acc_wen) ? '0 : rd_sh;
      err_d   = fault;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Captured request is pure data; its contents only matter once the FSM has left IDLE.
  always_ff @(posedge clk) begin
    wen_q   <= wen_d;
    size_q  <= size_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_mem_responder.sv
// Self-checking bench: two responders (LATENCY=2 and LATENCY=0) driven from shared
// request fields, checked against a byte-level memory model kept per instance.
module tb_ysyx_22041211_mem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, rst0, v2, v0, rr2, rr0, wen;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        qr2, qr0, rv2, rv0, re2, re0;
  logic [31:0] rd2, rd0;

  int checks = 0;
  int failures = 0;
  logic [31:0] m2 [int];
  logic [31:0] m0 [int];
  logic [31:0] got_rd2, got_rd0;
  logic        got_err2, got_err0;

  ysyx_22041211_mem_responder #(.LATENCY(2)) dut2 (
    .clk(clk), .rst(rst2), .req_valid(v2), .req_ready(qr2), .req_wen(wen),
    .req_size(size), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv2),
    .rsp_ready(rr2), .rsp_rdata(rd2), .rsp_err(re2));

  ysyx_22041211_mem_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst0), .req_valid(v0), .req_ready(qr0), .req_wen(wen),
    .req_size(size), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv0),
    .rsp_ready(rr0), .rsp_rdata(rd0), .rsp_err(re0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] getw(input bit sel0, input int i);
    if (sel0) return m0.exists(i) ? m0[i] : 32'h0;
    return m2.exists(i) ? m2[i] : 32'h0;
  endfunction

  function automatic void setw(input bit sel0, input int i, input logic [31:0] v);
    if (sel0) m0[i] = v;
    else m2[i] = v;
  endfunction

  // Byte-by-byte reference: n = 2^size bytes starting at byte b of the word.
  function automatic void model(input bit sel0, input logic w, input logic [1:0] s,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output logic err);
    logic [31:0] off;
    logic [31:0] word;
    int b, n;
    off = a - BASE;
    b   = int'(a[1:0]);
    n   = 1 << s;
    rd  = 32'h0;
    err = (off >= 32'd4096) || (s == 2'd3) || ((b % n) != 0);
    if (err) return;
    word = getw(sel0, int'(off >> 2));
    for (int k = 0; k < n; k++) begin
      if (w) word[8*(b+k) +: 8] = d[8*k +: 8];
      else   rd[8*k +: 8] = word[8*(b+k) +: 8];
    end
    if (w) setw(sel0, int'(off >> 2), word);
  endfunction

  task automatic xact(input bit u2, input bit u0, input logic w, input logic [1:0] s,
                      input logic [31:0] a, input logic [31:0] d, input string tag);
    logic [31:0] e2, e0;
    logic x2, x0;
    bit dn2, dn0;
    dn2 = !u2;
    dn0 = !u0;
    e2 = 0; e0 = 0; x2 = 0; x0 = 0;
    @(negedge clk);
    wen = w; size = s; addr = a; wdata = d; v2 = u2; v0 = u0; rr2 = 1'b1; rr0 = 1'b1;
    if (u2) begin chk({tag, "/ready2"}, 32'(qr2), 32'd1); model(1'b0, w, s, a, d, e2, x2); end
    if (u0) begin chk({tag, "/ready0"}, 32'(qr0), 32'd1); model(1'b1, w, s, a, d, e0, x0); end
    @(posedge clk);
    #1;
    v2 = 1'b0; v0 = 1'b0;
    wen = ~w; addr = $urandom; wdata = $urandom; size = 2'($urandom);
    for (int c = 1; c <= 20 && !(dn2 && dn0); c++) begin
      @(negedge clk);
      if (!dn2 && rv2) begin
        dn2 = 1'b1; got_rd2 = rd2; got_err2 = re2;
        chk({tag, "/lat2"}, 32'(c), 32'd3);
        chk({tag, "/rdata2"}, rd2, e2);
        chk({tag, "/err2"}, 32'(re2), 32'(x2));
      end
      if (!dn0 && rv0) begin
        dn0 = 1'b1; got_rd0 = rd0; got_err0 = re0;
        chk({tag, "/lat0"}, 32'(c), 32'd1);
        chk({tag, "/rdata0"}, rd0, e0);
        chk({tag, "/err0"}, 32'(re0), 32'(x0));
      end
    end
    if (!dn2) chk({tag, "/timeout2"}, 32'd0, 32'd1);
    if (!dn0) chk({tag, "/timeout0"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] e;
    logic        x;
    bit          seen;
    rst2 = 1'b0; rst0 = 1'b0; v2 = 1'b0; v0 = 1'b0; rr2 = 1'b1; rr0 = 1'b1;
    wen = 1'b0; size = 2'd0; addr = 32'h0; wdata = 32'h0;
    got_rd2 = 0; got_rd0 = 0; got_err2 = 0; got_err0 = 0;
    repeat (2) @(negedge clk);
    chk("rst/ready2", 32'(qr2), 32'd1);
    chk("rst/valid2", 32'(rv2), 32'd0);
    chk("rst/rdata2", rd2, 32'h0);
    chk("rst/err2", 32'(re2), 32'd0);
    chk("rst/ready0", 32'(qr0), 32'd1);
    chk("rst/valid0", 32'(rv0), 32'd0);
    chk("rst/rdata0", rd0, 32'h0);
    chk("rst/err0", 32'(re0), 32'd0);
    rst2 = 1'b1; rst0 = 1'b1;

    xact(1, 1, 1'b1, 2'd2, BASE + 32'h10, 32'hDEAD_BEEF, "t1_st");
    chk("t1_st/rdata", got_rd2, 32'h0);
    xact(1, 1, 1'b0, 2'd2, BASE + 32'h10, 32'h0, "t1_ld");
    chk("t1_ld/const2", got_rd2, 32'hDEAD_BEEF);
    chk("t1_ld/const0", got_rd0, 32'hDEAD_BEEF);

    xact(1, 1, 1'b1, 2'd0, BASE + 32'h12, 32'h0000_00A5, "t2_st");
    xact(1, 1, 1'b0, 2'd2, BASE + 32'h10, 32'h0, "t2_ldw");
    chk("t2_ldw/const", got_rd2, 32'hDEA5_BEEF);
    xact(1, 1, 1'b0, 2'd0, BASE + 32'h12, 32'h0, "t2_ldb");
    chk("t2_ldb/const", got_rd0, 32'h0000_00A5);

    xact(1, 1, 1'b0, 2'd1, BASE + 32'h12, 32'h0, "t3_ldh");
    chk("t3_ldh/const", got_rd2, 32'h0000_DEA5);
    xact(1, 1, 1'b0, 2'd1, BASE + 32'h11, 32'h0, "t3_mis");
    chk("t3_mis/err", 32'(got_err2), 32'd1);
    xact(1, 1, 1'b1, 2'd2, BASE + 32'h11, 32'h1111_1111, "t3_mis_st");
    xact(1, 1, 1'b0, 2'd2, BASE + 32'h10, 32'h0, "t3_chk");
    chk("t3_chk/const", got_rd2, 32'hDEA5_BEEF);

    xact(1, 1, 1'b1, 2'd2, BASE, 32'h1234_5678, "t4_init");
    xact(1, 1, 1'b1, 2'd2, 32'h7FFF_FFFC, 32'hFFFF_FFFF, "t4_lo");
    chk("t4_lo/err", 32'(got_err2), 32'd1);
    xact(1, 1, 1'b1, 2'd2, BASE + 32'd4096, 32'hFFFF_FFFF, "t4_hi");
    chk("t4_hi/err", 32'(got_err0), 32'd1);
    xact(1, 1, 1'b0, 2'd2, BASE, 32'h0, "t4_chk");
    chk("t4_chk/const", got_rd2, 32'h1234_5678);
    xact(1, 1, 1'b0, 2'd3, BASE, 32'h0, "t4_rsvd");

    // Stalled response on the LATENCY=2 instance.
    @(negedge clk);
    wen = 1'b1; size = 2'd0; addr = BASE + 32'h11; wdata = 32'h0000_003C; v2 = 1'b1; rr2 = 1'b0;
    model(1'b0, 1'b1, 2'd0, BASE + 32'h11, 32'h0000_003C, e, x);
    @(posedge clk);
    #1 v2 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = rv2;
    end
    chk("t5/resp_seen", 32'(seen), 32'd1);
    repeat (5) begin
      @(negedge clk);
      addr = $urandom; wdata = $urandom; wen = 1'($urandom);
      chk("t5/valid", 32'(rv2), 32'd1);
      chk("t5/rdata", rd2, 32'h0);
      chk("t5/err", 32'(re2), 32'd0);
      chk("t5/ready", 32'(qr2), 32'd0);
    end
    rr2 = 1'b1;
    @(negedge clk);
    chk("t5/released", 32'(rv2), 32'd0);
    xact(1, 0, 1'b0, 2'd2, BASE + 32'h10, 32'h0, "t5_rb");
    chk("t5_rb/const", got_rd2, 32'hDEA5_3CEF);

    // Reset while the LATENCY=2 store is still waiting.
    @(negedge clk);
    wen = 1'b1; size = 2'd2; addr = BASE + 32'h10; wdata = 32'h0BAD_F00D; v2 = 1'b1;
    @(posedge clk);
    #1 v2 = 1'b0;
    @(negedge clk);
    chk("t6/busy_ready", 32'(qr2), 32'd0);
    rst2 = 1'b0;
    #1;
    chk("t6/valid", 32'(rv2), 32'd0);
    chk("t6/ready", 32'(qr2), 32'd1);
    chk("t6/rdata", rd2, 32'h0);
    @(negedge clk);
    chk("t6/no_resp", 32'(rv2), 32'd0);
    rst2 = 1'b1;
    xact(1, 0, 1'b0, 2'd2, BASE + 32'h10, 32'h0, "t6_rb");
    chk("t6_rb/const", got_rd2, 32'hDEA5_3CEF);

    // LATENCY=0: the store commits on the accept edge, reset then drops the response.
    @(negedge clk);
    wen = 1'b1; size = 2'd2; addr = BASE + 32'h10; wdata = 32'h0BAD_F00D; v0 = 1'b1;
    model(1'b1, 1'b1, 2'd2, BASE + 32'h10, 32'h0BAD_F00D, e, x);
    @(posedge clk);
    #1 v0 = 1'b0;
    @(negedge clk);
    chk("t6z/valid_1cyc", 32'(rv0), 32'd1);
    rst0 = 1'b0;
    #1;
    chk("t6z/valid", 32'(rv0), 32'd0);
    chk("t6z/ready", 32'(qr0), 32'd1);
    @(negedge clk);
    rst0 = 1'b1;
    xact(0, 1, 1'b0, 2'd2, BASE + 32'h10, 32'h0, "t6z_rb");
    chk("t6z_rb/const", got_rd0, 32'h0BAD_F00D);

    for (int i = 0; i < 16; i++) xact(1, 1, 1'b1, 2'd2, BASE + 32'(4 * i), $urandom, "rnd_fill");
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 7))
        0:       a = BASE + 32'd4096 + 32'($urandom_range(0, 255));
        1:       a = BASE - 32'($urandom_range(1, 64));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      xact(1, 1, 1'($urandom), 2'($urandom_range(0, 3)), a, $urandom, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
